// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        HOLD,
        RUN,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into little-endian 32-bit words, one lane per accepted byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    localparam int IW = $clog2(BYTES_PER_WORD);

    logic [BYTES_PER_WORD-1:0][7:0] lanes;
    logic [IW-1:0]                  idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes <= '0;
            idx   <= '0;
        end else if (clear) begin
            lanes <= '0;
            idx   <= '0;
        end else if (byte_en) begin
            for (int i = 0; i < BYTES_PER_WORD; i++)
                if (idx == IW'(i)) lanes[i] <= byte_in;
            idx <= idx + IW'(1);
        end
    end

    assign word_out = lanes;
    // Asserted on the accept that completes the word, so the FSM can enter WRITE next cycle.
    assign word_full = byte_en && (idx == IW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, then releases core reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    localparam int TW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    state_t                   state, state_nx;
    logic [7:0]               len_lo;
    logic [LEN_BYTES*8-1:0]   len, len_in;
    logic [ADDR_W:0]          wcnt;
    logic [TW-1:0]            hold_cnt;
    logic                     acc, pk_en, pk_clear, pk_full;
    logic                     last_word, hold_done, oversize;
    logic [31:0]              pk_word;

    // Ready depends only on state; rst gating keeps it low while reset is held.
    assign s_ready   = (state inside {LEN_LO, LEN_HI, DATA}) && !rst;
    assign acc       = s_valid && s_ready;
    assign len_in    = {s_data, len_lo};
    assign oversize  = 32'(len_in) > (32'd1 << ADDR_W);
    assign last_word = (32'(wcnt) + 32'd1) == 32'(len);
    assign hold_done = hold_cnt == TW'(RELEASE_DELAY - 1);

    word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pk_clear),
        .byte_en  (pk_en),
        .byte_in  (s_data),
        .word_out (pk_word),
        .word_full(pk_full)
    );

    always_comb begin
        state_nx = state;
        pk_en    = 1'b0;
        pk_clear = 1'b0;
        unique case (state)
            LEN_LO: if (acc) state_nx = LEN_HI;
            LEN_HI: if (acc) begin
                pk_clear = 1'b1;
                if (len_in == '0)  state_nx = HOLD;
                else if (oversize) state_nx = ERR;
                else               state_nx = DATA;
            end
            DATA: if (acc) begin
                pk_en = 1'b1;
                if (pk_full) state_nx = WRITE;
            end
            WRITE: state_nx = last_word ? HOLD : DATA;
            HOLD:  if (hold_done) state_nx = RUN;
            RUN, ERR: if (reload) begin
                state_nx = LEN_LO;
                pk_clear = 1'b1;
            end
            default: state_nx = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LEN_LO;
            len_lo   <= '0;
            len      <= '0;
            wcnt     <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == LEN_LO && acc) len_lo <= s_data;
            if (state == LEN_HI && acc) begin
                len  <= len_in;
                wcnt <= '0;
            end
            if (state == WRITE && !last_word) wcnt <= wcnt + 1'b1;
            if ((state == RUN || state == ERR) && reload) wcnt <= '0;
            hold_cnt <= (state == HOLD) ? hold_cnt + TW'(1) : '0;
        end
    end

    // Word index never exceeds depth-1, so the low ADDR_W bits are the address.
    assign mem_we     = state == WRITE;
    assign mem_addr   = wcnt[ADDR_W-1:0];
    assign mem_wdata  = pk_word;
    assign core_rst_n = state == RUN;
    assign done       = state == RUN;
    assign err        = state == ERR;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

    localparam int AW = 2;
    localparam int D  = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready;
    logic          reload = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst_n, done, err;

    imem_loader #(.ADDR_W(AW), .RELEASE_DELAY(D)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, rise_cyc = -1;
    bit noise = 0;
    logic prev_crn = 1'b0;
    int          acc_cyc[$];
    logic [7:0]  acc_byte[$];
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Passive monitor: logs accepts and writes with their cycle numbers.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc);
                acc_byte.push_back(s_data);
            end
            if (mem_we) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(32'(mem_addr));
                wr_data.push_back(mem_wdata);
                check("ready_in_write", 32'(s_ready), 32'd0);
            end
            if (core_rst_n && !prev_crn && rise_cyc < 0) rise_cyc = cyc;
        end
        prev_crn = core_rst_n;
    end

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        reload  = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        bit sent = 0;
        while (!sent && guard < 100) begin
            @(negedge clk);
            reload = noise ? ($urandom_range(3) == 0) : 1'b0;
            if (int'($urandom_range(99)) < gap) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = b;
            end
            sent = s_valid && s_ready;
            guard++;
        end
        if (!sent) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] st[$], input int gap);
        int n, base, guard, k;
        logic [31:0] w;
        if (done || err) pulse_reload();
        acc_cyc.delete(); acc_byte.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rise_cyc = -1;
        foreach (st[i]) send_byte(st[i], gap);
        idle();
        n = int'({st[1], st[0]});
        guard = 0;
        while (!(done || err) && guard < 60) begin
            @(negedge clk); #3;
            guard++;
        end
        if (n > DEPTH) begin
            check("err_flag", 32'(err), 32'd1);
            check("err_crn", 32'(core_rst_n), 32'd0);
            check("err_nowrites", 32'(wr_data.size()), 32'd0);
            return;
        end
        check("done", 32'(done), 32'd1);
        check("crn_released", 32'(core_rst_n), 32'd1);
        check("wr_count", 32'(wr_data.size()), 32'(n));
        check("acc_count", 32'(acc_byte.size()), 32'(st.size()));
        for (int i = 0; i < st.size() && i < acc_byte.size(); i++)
            check("stream_byte", 32'(acc_byte[i]), 32'(st[i]));
        for (int i = 0; i < n && i < wr_data.size(); i++) begin
            k = 2 + 4 * i;
            w = {st[k+3], st[k+2], st[k+1], st[k]};
            check("wr_addr", wr_addr[i], 32'(i));
            check("wr_data", wr_data[i], w);
            if (acc_cyc.size() > k + 3)
                check("wr_latency", 32'(wr_cyc[i]), 32'(acc_cyc[k+3] + 1));
        end
        if (n == 0 && acc_cyc.size() > 1) base = acc_cyc[1];
        else if (n > 0 && wr_cyc.size() >= n) base = wr_cyc[n-1];
        else base = -100;
        check("release_time", 32'(rise_cyc), 32'(base + D + 1));
    endtask

    task automatic rand_stream(input int n, output logic [7:0] st[$]);
        st.delete();
        st.push_back(8'(n));
        st.push_back(8'(n >> 8));
        if (n <= DEPTH)
            for (int i = 0; i < 4 * n; i++) st.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] st[$];
        int n;
        #12;
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_ctl", 32'({s_ready, mem_we, mem_addr, core_rst_n, done, err}), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("ready_after_rst", 32'(s_ready), 32'd1);

        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(st, 0);

        st = '{8'h00, 8'h00};
        run_load(st, 0);
        check("zero_nowrites", 32'(wr_data.size()), 32'd0);

        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(st, 45);

        st = '{8'h05, 8'h00};
        run_load(st, 0);
        repeat (3) @(negedge clk);
        #3;
        check("err_hold", 32'(err), 32'd1);
        check("err_crn_hold", 32'(core_rst_n), 32'd0);
        check("err_no_ready", 32'(s_ready), 32'd0);
        pulse_reload(); #3;
        check("err_reload_ready", 32'(s_ready), 32'd1);
        check("err_reload_clear", 32'(err), 32'd0);

        st = '{8'h02, 8'h00, 8'h13, 8'h00};
        foreach (st[i]) send_byte(st[i], 0);
        idle(); #3;
        rst = 1'b1; #1;
        check("midrst_wdata", mem_wdata, 32'd0);
        check("midrst_ctl", 32'({s_ready, mem_we, mem_addr, core_rst_n, done, err}), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("midrst_ready", 32'(s_ready), 32'd1);
        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(st, 20);

        pulse_reload(); #3;
        check("reload_crn", 32'(core_rst_n), 32'd0);
        check("reload_done", 32'(done), 32'd0);
        check("reload_ready", 32'(s_ready), 32'd1);
        st = '{8'h01, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        run_load(st, 0);

        rand_stream(DEPTH, st);
        run_load(st, 30);

        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(0, DEPTH + 1));
            rand_stream(n, st);
            noise = 1;
            run_load(st, int'($urandom_range(0, 60)));
            noise = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
